// File: rtl/instr_mem_loader.sv
// Instruction memory with a registered, stallable fetch port. A byte-serial
// load port writes words at run time, and a clear engine fills the array with NOPs.
module instr_mem_loader #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 12,
  parameter int                DEPTH     = 4096,
  parameter logic [DATA_W-1:0] NOP_INSTR = 16'h6F0F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              clr_start,
  output logic              busy,
  output logic              ld_done,
  output logic [ADDR_W-1:0] ld_count
);

  localparam int                BPW       = DATA_W / 8;
  localparam int                BC_W      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BPW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_t;
  state_t state, next_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] clr_addr;
  logic [BC_W-1:0]   byte_cnt;
  logic [DATA_W-1:0] asm_reg;
  logic [DATA_W-1:0] asm_next;
  logic              word_done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              pc_oob;

  // Bytes arrive MSB first, so each new byte shifts in at the bottom.
  assign asm_next  = (asm_reg << 8) | DATA_W'(rx_data);
  assign word_done = (state == LOAD) && rx_valid && (byte_cnt == LAST_BYTE);
  assign busy      = (state != IDLE);
  assign ld_done   = (state == DONE);

  // A fetch address beyond the array only exists when the array is smaller than the address space.
  generate
    if (DEPTH < (2 ** ADDR_W)) begin : g_oob
      assign pc_oob = (pc > LAST_ADDR);
    end else begin : g_no_oob
      assign pc_oob = 1'b0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and a single shared write port for the load and clear paths.
  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = asm_next;
    case (state)
      IDLE: begin
        if (clr_start)     next_state = CLEAR;
        else if (ld_start) next_state = (ld_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (word_done) begin
          mem_we = 1'b1;
          if ((ld_count + 1'b1) == len_q) next_state = DONE;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = NOP_INSTR;
        if (clr_addr == LAST_ADDR) next_state = IDLE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Load/clear bookkeeping: write pointer, word count, byte assembly, clear pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr  <= '0;
      len_q    <= '0;
      ld_count <= '0;
      byte_cnt <= '0;
      asm_reg  <= '0;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            clr_addr <= '0;
          end else if (ld_start) begin
            wr_addr  <= ld_base;
            len_q    <= ld_len;
            ld_count <= '0;
            byte_cnt <= '0;
            asm_reg  <= '0;
          end
        end
        LOAD: begin
          if (rx_valid) begin
            asm_reg <= asm_next;
            if (word_done) begin
              byte_cnt <= '0;
              ld_count <= ld_count + 1'b1;
              wr_addr  <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        CLEAR:   clr_addr <= clr_addr + 1'b1;
        default: ;
      endcase
    end
  end

  // Memory array; contents survive reset, but no write lands in a reset cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  // Fetch register: bubbles whenever the controller is or is about to be busy, holds on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if ((state != IDLE) || (next_state != IDLE)) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (fetch_en) begin
      instr       <= pc_oob ? NOP_INSTR : mem[pc];
      instr_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instr_mem_loader;

  localparam int          DEPTH = 4096;
  localparam logic [15:0] NOP   = 16'h6F0F;

  logic        clk;
  logic        reset;
  logic [11:0] pc;
  logic        fetch_en;
  logic [15:0] instr;
  logic        instr_valid;
  logic        ld_start;
  logic [11:0] ld_base;
  logic [11:0] ld_len;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        clr_start;
  logic        busy;
  logic        ld_done;
  logic [11:0] ld_count;

  instr_mem_loader dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en),
    .instr(instr), .instr_valid(instr_valid),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .rx_valid(rx_valid), .rx_data(rx_data), .clr_start(clr_start),
    .busy(busy), .ld_done(ld_done), .ld_count(ld_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 loading, 2 clearing, 3 done pulse.
  logic [15:0] m_mem [DEPTH];
  int          m_mode = 0;
  int          m_pre = 0;
  int          m_addr = 0;
  int          m_len = 0;
  int          m_count = 0;
  int          m_nbytes = 0;
  int          m_clr_left = 0;
  logic [15:0] m_word = 16'h0;
  logic [15:0] e_instr = 16'h0;
  logic        e_valid = 1'b0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_count = 0; m_nbytes = 0; m_word = 16'h0;
      e_instr = NOP; e_valid = 1'b0; started = 1'b1;
    end else begin
      m_pre = m_mode;
      case (m_mode)
        0: begin
          if (clr_start) begin
            m_mode = 2; m_clr_left = DEPTH;
          end else if (ld_start) begin
            m_addr = int'(ld_base); m_len = int'(ld_len); m_count = 0;
            m_nbytes = 0; m_word = 16'h0;
            m_mode = (ld_len == 12'd0) ? 3 : 1;
          end
        end
        1: begin
          if (rx_valid) begin
            m_word = {m_word[7:0], rx_data};
            m_nbytes++;
            if (m_nbytes == 2) begin
              m_mem[m_addr] = m_word;
              m_addr = (m_addr + 1) % DEPTH;
              m_count++;
              m_nbytes = 0;
              if (m_count == m_len) m_mode = 3;
            end
          end
        end
        2: begin
          m_clr_left--;
          if (m_clr_left == 0) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
            m_mode = 0;
          end
        end
        default: m_mode = 0;
      endcase
      if (m_pre != 0 || m_mode != 0) begin
        e_instr = NOP; e_valid = 1'b0;
      end else if (fetch_en) begin
        e_instr = m_mem[pc]; e_valid = 1'b1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int busy_total = 0;
  int done_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (started) begin
        busy_total += (busy === 1'b1) ? 1 : 0;
        done_total += (ld_done === 1'b1) ? 1 : 0;
        chk("cyc_busy", 32'(busy), 32'(m_mode != 0));
        chk("cyc_ld_done", 32'(ld_done), 32'(m_mode == 3));
        chk("cyc_ld_count", 32'(ld_count), 32'(m_count));
        chk("cyc_instr_valid", 32'(instr_valid), 32'(e_valid));
        chk("cyc_instr", 32'(instr), 32'(e_instr));
      end
    end
  endtask

  task automatic pulse_ld(input logic [11:0] base, input logic [11:0] len);
    ld_start = 1'b1; ld_base = base; ld_len = len;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic fetch(input logic [11:0] a);
    pc = a; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0;
    logic [7:0] bytes2 [4];
    reset = 1'b1; pc = '0; fetch_en = 1'b0; ld_start = 1'b0; ld_base = '0;
    ld_len = '0; rx_valid = 1'b0; rx_data = '0; clr_start = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_instr", 32'(instr), 32'(NOP));
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld_count", 32'(ld_count), 32'd0);

    // Full clear
    b0 = busy_total;
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    repeat (DEPTH + 2) tick();
    chk("clr_busy_cycles", 32'(busy_total - b0), 32'(DEPTH));
    fetch(12'd100);
    chk("clr_fetch_instr", 32'(instr), 32'h6F0F);
    chk("clr_fetch_valid", 32'(instr_valid), 32'd1);

    // Two-word load with random gaps
    bytes2[0] = 8'h0D; bytes2[1] = 8'h00; bytes2[2] = 8'h0D; bytes2[3] = 8'h41;
    d0 = done_total;
    pulse_ld(12'd100, 12'd2);
    for (int i = 0; i < 4; i++) send_byte(bytes2[i], int'($urandom_range(0, 5)));
    wait_idle(20);
    chk("ld_done_pulses", 32'(done_total - d0), 32'd1);
    chk("ld_count_2", 32'(ld_count), 32'd2);
    fetch(12'd100);
    chk("ld_word0", 32'(instr), 32'h0D00);
    fetch(12'd101);
    chk("ld_word1", 32'(instr), 32'h0D41);

    // Stall
    fetch(12'd100);
    pc = 12'd101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", 32'(instr), 32'h0D00);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    fetch(12'd101);
    chk("stall_release", 32'(instr), 32'h0D41);

    // Address wrap
    pulse_ld(12'd4095, 12'd2);
    send_byte(8'h11, 0); send_byte(8'h11, 1); send_byte(8'h22, 2); send_byte(8'h22, 0);
    wait_idle(20);
    fetch(12'd4095);
    chk("wrap_last", 32'(instr), 32'h1111);
    fetch(12'd0);
    chk("wrap_first", 32'(instr), 32'h2222);

    // Zero-length load
    b0 = busy_total; d0 = done_total;
    pulse_ld(12'd300, 12'd0);
    chk("len0_done_now", 32'(ld_done), 32'd1);
    tick();
    chk("len0_done_gone", 32'(ld_done), 32'd0);
    chk("len0_busy_cycles", 32'(busy_total - b0), 32'd1);
    chk("len0_done_pulses", 32'(done_total - d0), 32'd1);
    chk("len0_count", 32'(ld_count), 32'd0);
    fetch(12'd4095);
    chk("len0_mem_kept", 32'(instr), 32'h1111);

    // Simultaneous ld_start and clr_start: clear wins
    b0 = busy_total; d0 = done_total;
    clr_start = 1'b1; ld_start = 1'b1; ld_base = 12'd50; ld_len = 12'd3;
    tick();
    clr_start = 1'b0; ld_start = 1'b0;
    wait_idle(DEPTH + 10);
    chk("both_busy_cycles", 32'(busy_total - b0), 32'(DEPTH));
    chk("both_no_done", 32'(done_total - d0), 32'd0);
    fetch(12'd4095);
    chk("both_cleared", 32'(instr), 32'h6F0F);

    // Reset in the middle of a load
    pulse_ld(12'd200, 12'd2);
    send_byte(8'hAB, 1); send_byte(8'hCD, 0); send_byte(8'hEF, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    d0 = done_total;
    send_byte(8'h12, 0);
    send_byte(8'h34, 1);
    tick();
    chk("midrst_rx_ignored", 32'(busy), 32'd0);
    chk("midrst_no_done", 32'(done_total - d0), 32'd0);
    fetch(12'd200);
    chk("midrst_word0", 32'(instr), 32'hABCD);
    fetch(12'd201);
    chk("midrst_word1", 32'(instr), 32'h6F0F);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
